reorder_buffer: RTL and testbench
=================================

# reorder_buffer

16-entry circular reorder buffer that allocates rename tags at issue, collects results from the ALU and load/store result buses, and retires instructions in program order, one per cycle. It drives the register file's commit port (`commit`, `commit_rd`, `commit_val`, `commit_rob_pos`) and its `rollback` input. It also answers the decoder's operand queries for renamed registers and detects branch mispredictions at retirement.

## Interface
Parameters:
- `ROB_BITS`, 4: index width; depth is 2^ROB_BITS = 16.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `rdy`  in  1  global enable; low freezes every register, outputs included.
- `issue`  in  1  allocate the tail entry this cycle.
- `issue_rd`  in  5  destination register; 0 means no write.
- `issue_kind`  in  2  entry kind: 0 = reg-write, 1 = branch, 2 = store.
- `issue_pred_taken`  in  1  predicted direction, branches only.
- `issue_ready`  in  1  result already known at issue (e.g. LUI).
- `issue_val`  in  32  result when `issue_ready` is high.
- `issue_rob_pos`  out  4  tail index; combinational.
- `rob_full`  out  1  count == 16; combinational from state.
- `alu_result`  in  1  ALU result bus valid.
- `alu_rob_pos`  in  4  tag of the ALU result.
- `alu_val`  in  32  ALU result value.
- `alu_jump`  in  1  actual branch taken.
- `alu_pc`  in  32  actual next PC.
- `lsb_result`  in  1  load/store result bus valid.
- `lsb_rob_pos`  in  4  tag of the LSB result.
- `lsb_val`  in  32  load data; ignored for stores.
- `rs1_rob_id`, `rs2_rob_id`  in  4  tags being queried.
- `rs1_ready`, `rs2_ready`  out  1  queried entry has its value; combinational.
- `rs1_val`, `rs2_val`  out  32  queried value; combinational.
- `commit`  out  1  registered pulse: reg-write retired.
- `commit_rd`  out  5  destination of the retired entry.
- `commit_val`  out  32  result of the retired entry.
- `commit_rob_pos`  out  4  index of the retired entry; valid with `commit` or `commit_store`.
- `commit_store`  out  1  registered pulse: store retired; LSB may write memory.
- `rollback`  out  1  registered pulse: mispredict flush.
- `set_pc_en`  out  1  registered pulse, coincident with `rollback`.
- `set_pc`  out  32  redirect PC.

## Operation
- State: `head`, `tail` (4-bit, wrap 15→0), 5-bit `count`.
- Per-entry state: `busy`, `ready`, `kind`, `rd`, `val`, `pred`, `jump`, `pc`.
- Issue (accepted when `issue && !rob_full && !rollback`):
  - Entry[tail] ← busy=1, ready=`issue_ready`, plus the issue fields.
  - tail+1, count+1.
  - Issue while full is ignored; the decoder must not issue when `rob_full` is high.
- Writeback: for each valid bus whose tag hits a busy entry, set ready=1 and store val.
  - The ALU bus also stores jump/pc.
  - Both buses may write different entries in the same cycle.
  - A write to a non-busy entry is ignored.
- Query: ready = entry ready, or a same-cycle `alu_result`/`lsb_result` with a matching tag. The value is forwarded from that bus, with ALU taking priority.
- Retire: when entry[head] is busy and ready, clear busy, head+1, count−1, and by kind:
  - reg-write: `commit`=1 if rd≠0, with rd, val and index.
  - store: `commit_store`=1 with index.
  - branch with jump==pred: nothing emitted, and `commit` stays 0.
  - branch with jump≠pred: `rollback`=1, `set_pc_en`=1, `set_pc`=entry pc. All busy bits clear; head=tail=count=0. Issue and writeback in that same edge are discarded.
- Retire, issue and writeback on the same edge compose: count is unchanged when both issue and retire occur. An entry written back this edge retires no earlier than the next edge.
- Reset: all busy=0; head=tail=count=0; `commit`, `commit_store`, `rollback`, `set_pc_en`=0; `commit_rd`=0, `commit_val`=0, `commit_rob_pos`=0, `set_pc`=0.

## Timing
- Pulse outputs are registered and high for exactly one cycle, then return to 0 (unless `rdy` freezes them).
- Issue at edge E: the entry is visible from cycle E+1; `issue_rob_pos` advances after E.
- Writeback at edge E: the earliest retirement is edge E+1, so `commit` is high in the cycle after E+1.
- `issue_ready` entry issued at E as the head: it retires at E+1.
- Throughput: one retirement per cycle; no bubble between back-to-back ready entries.
- Full: count==16 asserts `rob_full`. Retiring that cycle frees a slot from the next cycle; it does not accept a same-cycle issue.
- Rollback is high in cycle R. Issue during R is ignored because `rollback` blocks acceptance, so the first accepted issue after rollback gets index 0. CDB results during R are ignored because no entry is busy.
- `rdy` low: no state changes and outputs hold their values. Downstream blocks freeze identically.

## Test plan
- Reset, then 3 reg-write issues (rd=1,2,3) with ALU results 0xA, 0xB, 0xC returned in reverse order → `commit` on 3 consecutive cycles: rd=1/0xA pos 0, rd=2/0xB pos 1, rd=3/0xC pos 2.
- Fill 16 entries → `rob_full`=1 and a 17th issue is ignored. Retire one → `rob_full`=0 next cycle; the next issue gets pos 0 (wrap).
- Branch at pos 0 with pred=0, ALU returns jump=1, pc=0x100, followed by pending entries 1–4 → `rollback`, `set_pc_en`=1, `set_pc`=0x100, no `commit`. The next accepted issue gets pos 0; a late result for tag 3 is ignored.
- Query `rs1_rob_id`=5 in the same cycle as `alu_result`, tag 5, val 0x55 → `rs1_ready`=1, `rs1_val`=0x55.
- Store at head, LSB result for its tag → `commit_store`=1 with its pos, `commit`=0. An entry with rd=0 retires with `commit`=0.
- Hold `rdy`=0 for 3 cycles with `commit` high → `commit` stays high and head is unchanged. Assert `rst` with 5 entries busy → `count`=0, all outputs 0 the next cycle.

Source files
------------

// File: rtl/reorder_buffer.sv
// 16-entry circular reorder buffer: allocates tags at issue, collects ALU/LSB results,
// retires in program order and flushes on a branch mispredict found at retirement.
module reorder_buffer #(
    parameter int unsigned ROB_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy_i,

    input  logic                issue_i,
    input  logic [4:0]          issue_rd_i,
    input  logic [1:0]          issue_kind_i,
    input  logic                issue_pred_taken_i,
    input  logic                issue_ready_i,
    input  logic [31:0]         issue_val_i,
    output logic [ROB_BITS-1:0] issue_rob_pos_o,
    output logic                rob_full_o,

    input  logic                alu_result_i,
    input  logic [ROB_BITS-1:0] alu_rob_pos_i,
    input  logic [31:0]         alu_val_i,
    input  logic                alu_jump_i,
    input  logic [31:0]         alu_pc_i,

    input  logic                lsb_result_i,
    input  logic [ROB_BITS-1:0] lsb_rob_pos_i,
    input  logic [31:0]         lsb_val_i,

    input  logic [ROB_BITS-1:0] rs1_rob_id_i,
    input  logic [ROB_BITS-1:0] rs2_rob_id_i,
    output logic                rs1_ready_o,
    output logic                rs2_ready_o,
    output logic [31:0]         rs1_val_o,
    output logic [31:0]         rs2_val_o,

    output logic                commit_o,
    output logic [4:0]          commit_rd_o,
    output logic [31:0]         commit_val_o,
    output logic [ROB_BITS-1:0] commit_rob_pos_o,
    output logic                commit_store_o,
    output logic                rollback_o,
    output logic                set_pc_en_o,
    output logic [31:0]         set_pc_o
);

    localparam int unsigned Depth = 1 << ROB_BITS;
    localparam logic [ROB_BITS:0] FullCount = {1'b1, {ROB_BITS{1'b0}}};

    localparam logic [1:0] KindReg    = 2'd0;
    localparam logic [1:0] KindBranch = 2'd1;
    localparam logic [1:0] KindStore  = 2'd2;

    logic [ROB_BITS-1:0] head_q, head_d;
    logic [ROB_BITS-1:0] tail_q, tail_d;
    logic [ROB_BITS:0]   count_q, count_d;

    logic [Depth-1:0]    busy_q, busy_d;
    logic [Depth-1:0]    ready_q, ready_d;
    logic [Depth-1:0]    pred_q, pred_d;
    logic [Depth-1:0]    jump_q, jump_d;
    logic [1:0]          kind_q [Depth];
    logic [1:0]          kind_d [Depth];
    logic [4:0]          rd_q   [Depth];
    logic [4:0]          rd_d   [Depth];
    logic [31:0]         val_q  [Depth];
    logic [31:0]         val_d  [Depth];
    logic [31:0]         pc_q   [Depth];
    logic [31:0]         pc_d   [Depth];

    logic                commit_q, commit_d;
    logic [4:0]          commit_rd_q, commit_rd_d;
    logic [31:0]         commit_val_q, commit_val_d;
    logic [ROB_BITS-1:0] commit_rob_pos_q, commit_rob_pos_d;
    logic                commit_store_q, commit_store_d;
    logic                rollback_q, rollback_d;
    logic                set_pc_en_q, set_pc_en_d;
    logic [31:0]         set_pc_q, set_pc_d;

    logic                issue_acc;
    logic                retire;
    logic                mispredict;

    assign issue_rob_pos_o  = tail_q;
    assign rob_full_o       = (count_q == FullCount);

    assign commit_o         = commit_q;
    assign commit_rd_o      = commit_rd_q;
    assign commit_val_o     = commit_val_q;
    assign commit_rob_pos_o = commit_rob_pos_q;
    assign commit_store_o   = commit_store_q;
    assign rollback_o       = rollback_q;
    assign set_pc_en_o      = set_pc_en_q;
    assign set_pc_o         = set_pc_q;

    // Retirement looks only at registered state, so a same-edge writeback waits a cycle.
    assign retire     = busy_q[head_q] & ready_q[head_q];
    assign mispredict = retire && (kind_q[head_q] == KindBranch) &&
                        (jump_q[head_q] != pred_q[head_q]);
    assign issue_acc  = issue_i && !rob_full_o && !rollback_q;

    always_comb begin
        head_d           = head_q;
        tail_d           = tail_q;
        count_d          = count_q;
        busy_d           = busy_q;
        ready_d          = ready_q;
        pred_d           = pred_q;
        jump_d           = jump_q;
        kind_d           = kind_q;
        rd_d             = rd_q;
        val_d            = val_q;
        pc_d             = pc_q;
        commit_d         = 1'b0;
        commit_store_d   = 1'b0;
        rollback_d       = 1'b0;
        set_pc_en_d      = 1'b0;
        commit_rd_d      = commit_rd_q;
        commit_val_d     = commit_val_q;
        commit_rob_pos_d = commit_rob_pos_q;
        set_pc_d         = set_pc_q;

        if (mispredict) begin
            // Flush wins over everything else on this edge.
            busy_d      = '0;
            ready_d     = '0;
            head_d      = '0;
            tail_d      = '0;
            count_d     = '0;
            rollback_d  = 1'b1;
            set_pc_en_d = 1'b1;
            set_pc_d    = pc_q[head_q];
        end else begin
            if (alu_result_i && busy_q[alu_rob_pos_i]) begin
                ready_d[alu_rob_pos_i] = 1'b1;
                val_d[alu_rob_pos_i]   = alu_val_i;
                jump_d[alu_rob_pos_i]  = alu_jump_i;
                pc_d[alu_rob_pos_i]    = alu_pc_i;
            end
            if (lsb_result_i && busy_q[lsb_rob_pos_i]) begin
                ready_d[lsb_rob_pos_i] = 1'b1;
                if (kind_q[lsb_rob_pos_i] != KindStore) begin
                    val_d[lsb_rob_pos_i] = lsb_val_i;
                end
            end

            if (retire) begin
                busy_d[head_q] = 1'b0;
                head_d         = head_q + 1'b1;
                case (kind_q[head_q])
                    KindReg: begin
                        if (rd_q[head_q] != 5'd0) begin
                            commit_d         = 1'b1;
                            commit_rd_d      = rd_q[head_q];
                            commit_val_d     = val_q[head_q];
                            commit_rob_pos_d = head_q;
                        end
                    end
                    KindStore: begin
                        commit_store_d   = 1'b1;
                        commit_rob_pos_d = head_q;
                    end
                    default: ;
                endcase
            end

            // The tail slot is never the retiring head: that needs count 0 or full.
            if (issue_acc) begin
                busy_d[tail_q]  = 1'b1;
                ready_d[tail_q] = issue_ready_i;
                kind_d[tail_q]  = issue_kind_i;
                rd_d[tail_q]    = issue_rd_i;
                val_d[tail_q]   = issue_val_i;
                pred_d[tail_q]  = issue_pred_taken_i;
                tail_d          = tail_q + 1'b1;
            end

            case ({issue_acc, retire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Operand query with same-cycle bypass; ALU takes priority over LSB.
    always_comb begin
        rs1_ready_o = ready_q[rs1_rob_id_i];
        rs1_val_o   = val_q[rs1_rob_id_i];
        if (lsb_result_i && (lsb_rob_pos_i == rs1_rob_id_i)) begin
            rs1_ready_o = 1'b1;
            rs1_val_o   = lsb_val_i;
        end
        if (alu_result_i && (alu_rob_pos_i == rs1_rob_id_i)) begin
            rs1_ready_o = 1'b1;
            rs1_val_o   = alu_val_i;
        end
    end

    always_comb begin
        rs2_ready_o = ready_q[rs2_rob_id_i];
        rs2_val_o   = val_q[rs2_rob_id_i];
        if (lsb_result_i && (lsb_rob_pos_i == rs2_rob_id_i)) begin
            rs2_ready_o = 1'b1;
            rs2_val_o   = lsb_val_i;
        end
        if (alu_result_i && (alu_rob_pos_i == rs2_rob_id_i)) begin
            rs2_ready_o = 1'b1;
            rs2_val_o   = alu_val_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            busy_q           <= '0;
            ready_q          <= '0;
            commit_q         <= 1'b0;
            commit_rd_q      <= '0;
            commit_val_q     <= '0;
            commit_rob_pos_q <= '0;
            commit_store_q   <= 1'b0;
            rollback_q       <= 1'b0;
            set_pc_en_q      <= 1'b0;
            set_pc_q         <= '0;
        end else if (rdy_i) begin
            head_q           <= head_d;
            tail_q           <= tail_d;
            count_q          <= count_d;
            busy_q           <= busy_d;
            ready_q          <= ready_d;
            pred_q           <= pred_d;
            jump_q           <= jump_d;
            kind_q           <= kind_d;
            rd_q             <= rd_d;
            val_q            <= val_d;
            pc_q             <= pc_d;
            commit_q         <= commit_d;
            commit_rd_q      <= commit_rd_d;
            commit_val_q     <= commit_val_d;
            commit_rob_pos_q <= commit_rob_pos_d;
            commit_store_q   <= commit_store_d;
            rollback_q       <= rollback_d;
            set_pc_en_q      <= set_pc_en_d;
            set_pc_q         <= set_pc_d;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: operand-query vector table, retirement
// scoreboard, and hand-written sequences for full, rollback, store and freeze cases.
module tb_reorder_buffer;

    localparam logic [1:0] EvCommit   = 2'd0;
    localparam logic [1:0] EvStore    = 2'd1;
    localparam logic [1:0] EvRollback = 2'd2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        issue = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic [1:0]  issue_kind = '0;
    logic        issue_pred_taken = 1'b0;
    logic        issue_ready = 1'b0;
    logic [31:0] issue_val = '0;
    logic [3:0]  issue_rob_pos;
    logic        rob_full;
    logic        alu_result = 1'b0;
    logic [3:0]  alu_rob_pos = '0;
    logic [31:0] alu_val = '0;
    logic        alu_jump = 1'b0;
    logic [31:0] alu_pc = '0;
    logic        lsb_result = 1'b0;
    logic [3:0]  lsb_rob_pos = '0;
    logic [31:0] lsb_val = '0;
    logic [3:0]  rs1_rob_id = '0;
    logic [3:0]  rs2_rob_id = '0;
    logic        rs1_ready, rs2_ready;
    logic [31:0] rs1_val, rs2_val;
    logic        commit;
    logic [4:0]  commit_rd;
    logic [31:0] commit_val;
    logic [3:0]  commit_rob_pos;
    logic        commit_store;
    logic        rollback;
    logic        set_pc_en;
    logic [31:0] set_pc;

    reorder_buffer #(.ROB_BITS(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .rdy_i              (rdy),
        .issue_i            (issue),
        .issue_rd_i         (issue_rd),
        .issue_kind_i       (issue_kind),
        .issue_pred_taken_i (issue_pred_taken),
        .issue_ready_i      (issue_ready),
        .issue_val_i        (issue_val),
        .issue_rob_pos_o    (issue_rob_pos),
        .rob_full_o         (rob_full),
        .alu_result_i       (alu_result),
        .alu_rob_pos_i      (alu_rob_pos),
        .alu_val_i          (alu_val),
        .alu_jump_i         (alu_jump),
        .alu_pc_i           (alu_pc),
        .lsb_result_i       (lsb_result),
        .lsb_rob_pos_i      (lsb_rob_pos),
        .lsb_val_i          (lsb_val),
        .rs1_rob_id_i       (rs1_rob_id),
        .rs2_rob_id_i       (rs2_rob_id),
        .rs1_ready_o        (rs1_ready),
        .rs2_ready_o        (rs2_ready),
        .rs1_val_o          (rs1_val),
        .rs2_val_o          (rs2_val),
        .commit_o           (commit),
        .commit_rd_o        (commit_rd),
        .commit_val_o       (commit_val),
        .commit_rob_pos_o   (commit_rob_pos),
        .commit_store_o     (commit_store),
        .rollback_o         (rollback),
        .set_pc_en_o        (set_pc_en),
        .set_pc_o           (set_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ev;
        logic [4:0]  rd;
        logic [31:0] val;
        logic [3:0]  pos;
    } exp_t;

    typedef struct {
        logic        alu_v;
        logic [3:0]  alu_pos;
        logic [31:0] alu_v32;
        logic        lsb_v;
        logic [3:0]  lsb_pos;
        logic [31:0] lsb_v32;
        logic [3:0]  q1;
        logic [3:0]  q2;
        logic        e1_rdy;
        logic [31:0] e1_val;
        logic        e2_rdy;
        logic [31:0] e2_val;
    } qvec_t;

    exp_t  exp_q[$];
    exp_t  mon_e;
    qvec_t qtab[6];
    int    n_checks = 0;
    int    n_pass   = 0;
    logic  act_edge = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    task automatic push(input logic [1:0] ev, input logic [4:0] rd, input logic [31:0] val,
                        input logic [3:0] pos);
        exp_t e;
        e.ev  = ev;
        e.rd  = rd;
        e.val = val;
        e.pos = pos;
        exp_q.push_back(e);
    endtask

    // Outputs only change on edges where the DUT was enabled and not in reset.
    always @(posedge clk) act_edge <= rdy && !rst;

    always @(negedge clk) begin
        if (act_edge && (commit || commit_store || rollback)) begin
            if (exp_q.size() == 0) begin
                check("unexpected retire event", {29'd0, rollback, commit_store, commit}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("retire event kind", {29'd0, rollback, commit_store, commit},
                      32'd1 << mon_e.ev);
                case (mon_e.ev)
                    EvCommit: begin
                        check("commit_rd", {27'd0, commit_rd}, {27'd0, mon_e.rd});
                        check("commit_val", commit_val, mon_e.val);
                        check("commit_rob_pos", {28'd0, commit_rob_pos}, {28'd0, mon_e.pos});
                    end
                    EvStore: begin
                        check("store commit_rob_pos", {28'd0, commit_rob_pos},
                              {28'd0, mon_e.pos});
                    end
                    default: begin
                        check("set_pc_en", {31'd0, set_pc_en}, 32'd1);
                        check("set_pc", set_pc, mon_e.val);
                    end
                endcase
            end
        end
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic [1:0] kind, input logic pred,
                            input logic rdyf, input logic [31:0] val, input logic [3:0] exp_pos);
        issue            = 1'b1;
        issue_rd         = rd;
        issue_kind       = kind;
        issue_pred_taken = pred;
        issue_ready      = rdyf;
        issue_val        = val;
        #1;
        check($sformatf("issue_rob_pos rd%0d", rd), {28'd0, issue_rob_pos}, {28'd0, exp_pos});
        tick();
        issue = 1'b0;
    endtask

    task automatic alu_wb(input logic [3:0] pos, input logic [31:0] val, input logic jump,
                          input logic [31:0] pc);
        alu_result  = 1'b1;
        alu_rob_pos = pos;
        alu_val     = val;
        alu_jump    = jump;
        alu_pc      = pc;
        tick();
        alu_result  = 1'b0;
    endtask

    task automatic lsb_wb(input logic [3:0] pos, input logic [31:0] val);
        lsb_result  = 1'b1;
        lsb_rob_pos = pos;
        lsb_val     = val;
        tick();
        lsb_result  = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("scoreboard drained", exp_q.size(), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        qtab[0] = '{1'b0, 4'd0, 32'h0,  1'b0, 4'd0, 32'h0,  4'd1, 4'd2, 1'b1, 32'h11, 1'b0, 32'h0};
        qtab[1] = '{1'b1, 4'd5, 32'h55, 1'b0, 4'd0, 32'h0,  4'd5, 4'd4, 1'b1, 32'h55, 1'b0, 32'h0};
        qtab[2] = '{1'b0, 4'd0, 32'h0,  1'b1, 4'd4, 32'h44, 4'd4, 4'd5, 1'b1, 32'h44, 1'b0, 32'h0};
        qtab[3] = '{1'b1, 4'd2, 32'hA2, 1'b1, 4'd2, 32'hB2, 4'd2, 4'd3, 1'b1, 32'hA2, 1'b1, 32'h33};
        qtab[4] = '{1'b1, 4'd5, 32'h5A, 1'b1, 4'd4, 32'h4B, 4'd4, 4'd5, 1'b1, 32'h4B, 1'b1, 32'h5A};
        qtab[5] = '{1'b0, 4'd0, 32'h0,  1'b0, 4'd0, 32'h0,  4'd7, 4'd0, 1'b0, 32'h0,  1'b0, 32'h0};

        // Reset state.
        tick();
        tick();
        rst = 1'b0;
        check("reset commit", {31'd0, commit}, 32'd0);
        check("reset commit_store", {31'd0, commit_store}, 32'd0);
        check("reset rollback", {31'd0, rollback}, 32'd0);
        check("reset set_pc_en", {31'd0, set_pc_en}, 32'd0);
        check("reset commit_rd", {27'd0, commit_rd}, 32'd0);
        check("reset commit_val", commit_val, 32'd0);
        check("reset commit_rob_pos", {28'd0, commit_rob_pos}, 32'd0);
        check("reset set_pc", set_pc, 32'd0);
        check("reset rob_full", {31'd0, rob_full}, 32'd0);
        check("reset issue_rob_pos", {28'd0, issue_rob_pos}, 32'd0);

        // Operand queries against a head-blocked buffer (pos1, pos3 ready at issue).
        do_issue(5'd0, 2'd0, 1'b0, 1'b0, 32'h0,  4'd0);
        do_issue(5'd0, 2'd0, 1'b0, 1'b1, 32'h11, 4'd1);
        do_issue(5'd0, 2'd0, 1'b0, 1'b0, 32'h0,  4'd2);
        do_issue(5'd0, 2'd0, 1'b0, 1'b1, 32'h33, 4'd3);
        do_issue(5'd0, 2'd0, 1'b0, 1'b0, 32'h0,  4'd4);
        do_issue(5'd0, 2'd0, 1'b0, 1'b0, 32'h0,  4'd5);
        for (int i = 0; i < 6; i++) begin
            alu_result  = qtab[i].alu_v;
            alu_rob_pos = qtab[i].alu_pos;
            alu_val     = qtab[i].alu_v32;
            lsb_result  = qtab[i].lsb_v;
            lsb_rob_pos = qtab[i].lsb_pos;
            lsb_val     = qtab[i].lsb_v32;
            rs1_rob_id  = qtab[i].q1;
            rs2_rob_id  = qtab[i].q2;
            #1;
            check($sformatf("query%0d rs1_ready", i), {31'd0, rs1_ready}, {31'd0, qtab[i].e1_rdy});
            check($sformatf("query%0d rs2_ready", i), {31'd0, rs2_ready}, {31'd0, qtab[i].e2_rdy});
            if (qtab[i].e1_rdy) check($sformatf("query%0d rs1_val", i), rs1_val, qtab[i].e1_val);
            if (qtab[i].e2_rdy) check($sformatf("query%0d rs2_val", i), rs2_val, qtab[i].e2_val);
            alu_result = 1'b0;
            lsb_result = 1'b0;
            tick();
        end
        do_reset();

        // Out-of-order writeback, in-order back-to-back commit.
        do_issue(5'd1, 2'd0, 1'b0, 1'b0, 32'h0, 4'd0);
        push(EvCommit, 5'd1, 32'hA, 4'd0);
        do_issue(5'd2, 2'd0, 1'b0, 1'b0, 32'h0, 4'd1);
        push(EvCommit, 5'd2, 32'hB, 4'd1);
        do_issue(5'd3, 2'd0, 1'b0, 1'b0, 32'h0, 4'd2);
        push(EvCommit, 5'd3, 32'hC, 4'd2);
        alu_wb(4'd2, 32'hC, 1'b0, 32'h0);
        alu_wb(4'd1, 32'hB, 1'b0, 32'h0);
        alu_wb(4'd0, 32'hA, 1'b0, 32'h0);
        check("no commit on writeback edge", {31'd0, commit}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("back-to-back commit %0d", k), {31'd0, commit}, 32'd1);
        end
        tick();
        check("commit pulse ends", {31'd0, commit}, 32'd0);
        check("ooo scoreboard empty", exp_q.size(), 32'd0);

        // Fill, ignored 17th issue, retire-while-full, wrap to pos 0.
        do_reset();
        for (int k = 0; k < 16; k++) begin
            do_issue(5'(k + 1), 2'd0, 1'b0, 1'b0, 32'h0, 4'(k));
            push(EvCommit, 5'(k + 1), 32'h100 + k, 4'(k));
        end
        check("rob_full after 16", {31'd0, rob_full}, 32'd1);
        issue    = 1'b1;
        issue_rd = 5'd31;
        tick();
        issue = 1'b0;
        check("17th issue ignored: full", {31'd0, rob_full}, 32'd1);
        check("17th issue ignored: tail", {28'd0, issue_rob_pos}, 32'd0);
        alu_wb(4'd0, 32'h100, 1'b0, 32'h0);
        check("full during retire cycle", {31'd0, rob_full}, 32'd1);
        issue    = 1'b1;
        issue_rd = 5'd30;
        tick();
        issue = 1'b0;
        check("slot freed after retire", {31'd0, rob_full}, 32'd0);
        check("same-cycle issue not taken", {28'd0, issue_rob_pos}, 32'd0);
        do_issue(5'd17, 2'd0, 1'b0, 1'b0, 32'h0, 4'd0);
        push(EvCommit, 5'd17, 32'h200, 4'd0);
        check("full again after wrap", {31'd0, rob_full}, 32'd1);
        alu_result  = 1'b1;
        alu_rob_pos = 4'd1;
        alu_val     = 32'h101;
        lsb_result  = 1'b1;
        lsb_rob_pos = 4'd0;
        lsb_val     = 32'h200;
        tick();
        alu_result = 1'b0;
        lsb_result = 1'b0;
        for (int k = 2; k < 16; k++) alu_wb(4'(k), 32'h100 + k, 1'b0, 32'h0);
        drain(40);

        // Mispredicted branch at pos 0 flushes pending entries.
        do_reset();
        do_issue(5'd0, 2'd1, 1'b0, 1'b0, 32'h0, 4'd0);
        push(EvRollback, 5'd0, 32'h100, 4'd0);
        for (int k = 1; k < 5; k++) do_issue(5'(k), 2'd0, 1'b0, 1'b0, 32'h0, 4'(k));
        alu_wb(4'd0, 32'h0, 1'b1, 32'h100);
        tick();
        check("rollback pulse", {31'd0, rollback}, 32'd1);
        check("rollback set_pc_en", {31'd0, set_pc_en}, 32'd1);
        check("rollback set_pc", set_pc, 32'h100);
        check("rollback no commit", {31'd0, commit}, 32'd0);
        check("rollback tail reset", {28'd0, issue_rob_pos}, 32'd0);
        issue       = 1'b1;
        issue_rd    = 5'd9;
        issue_ready = 1'b1;
        issue_val   = 32'h99;
        alu_result  = 1'b1;
        alu_rob_pos = 4'd3;
        alu_val     = 32'h33;
        tick();
        issue      = 1'b0;
        alu_result = 1'b0;
        rs1_rob_id = 4'd3;
        #1;
        check("rollback single cycle", {31'd0, rollback}, 32'd0);
        check("set_pc_en single cycle", {31'd0, set_pc_en}, 32'd0);
        check("issue during rollback ignored", {28'd0, issue_rob_pos}, 32'd0);
        check("late result ignored", {31'd0, rs1_ready}, 32'd0);
        do_issue(5'd5, 2'd0, 1'b0, 1'b1, 32'h77, 4'd0);
        push(EvCommit, 5'd5, 32'h77, 4'd0);
        check("ready-at-issue not yet retired", {31'd0, commit}, 32'd0);
        tick();
        check("ready-at-issue retires next edge", {31'd0, commit}, 32'd1);
        drain(10);

        // Store, rd=0 write, correctly predicted branch, then a normal write.
        do_issue(5'd0, 2'd2, 1'b0, 1'b0, 32'h0,  4'd1);
        push(EvStore, 5'd0, 32'h0, 4'd1);
        do_issue(5'd0, 2'd0, 1'b0, 1'b1, 32'h99, 4'd2);
        do_issue(5'd0, 2'd1, 1'b1, 1'b0, 32'h0,  4'd3);
        do_issue(5'd6, 2'd0, 1'b0, 1'b1, 32'h66, 4'd4);
        push(EvCommit, 5'd6, 32'h66, 4'd4);
        lsb_wb(4'd1, 32'hDEAD);
        alu_wb(4'd3, 32'h0, 1'b1, 32'h200);
        drain(10);

        // rdy low freezes a high commit pulse and the head.
        do_issue(5'd8, 2'd0, 1'b0, 1'b1, 32'h88, 4'd5);
        push(EvCommit, 5'd8, 32'h88, 4'd5);
        do_issue(5'd9, 2'd0, 1'b0, 1'b1, 32'h99, 4'd6);
        push(EvCommit, 5'd9, 32'h99, 4'd6);
        rdy         = 1'b0;
        issue       = 1'b1;
        issue_rd    = 5'd10;
        issue_ready = 1'b1;
        issue_val   = 32'hAA;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("frozen commit %0d", k), {31'd0, commit}, 32'd1);
            check($sformatf("frozen commit_rob_pos %0d", k), {28'd0, commit_rob_pos}, 32'd5);
            check($sformatf("frozen tail %0d", k), {28'd0, issue_rob_pos}, 32'd7);
            tick();
        end
        check("frozen commit after 3 cycles", {31'd0, commit}, 32'd1);
        check("frozen head after 3 cycles", {28'd0, commit_rob_pos}, 32'd5);
        rdy   = 1'b1;
        issue = 1'b0;
        tick();
        check("resume commit", {31'd0, commit}, 32'd1);
        check("resume commit_rob_pos", {28'd0, commit_rob_pos}, 32'd6);
        tick();
        check("resume commit ends", {31'd0, commit}, 32'd0);
        check("resume tail", {28'd0, issue_rob_pos}, 32'd7);
        drain(5);

        // Reset with five busy entries.
        for (int k = 0; k < 5; k++) do_issue(5'(11 + k), 2'd0, 1'b0, 1'b0, 32'h0, 4'(7 + k));
        do_reset();
        check("rst commit", {31'd0, commit}, 32'd0);
        check("rst commit_store", {31'd0, commit_store}, 32'd0);
        check("rst rollback", {31'd0, rollback}, 32'd0);
        check("rst set_pc_en", {31'd0, set_pc_en}, 32'd0);
        check("rst commit_rd", {27'd0, commit_rd}, 32'd0);
        check("rst commit_val", commit_val, 32'd0);
        check("rst commit_rob_pos", {28'd0, commit_rob_pos}, 32'd0);
        check("rst set_pc", set_pc, 32'd0);
        check("rst rob_full", {31'd0, rob_full}, 32'd0);
        check("rst tail", {28'd0, issue_rob_pos}, 32'd0);
        do_issue(5'd3, 2'd0, 1'b0, 1'b1, 32'h33, 4'd0);
        push(EvCommit, 5'd3, 32'h33, 4'd0);
        drain(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
